nonogram_line_scheduler: RTL and testbench

Sequencing controller for the nonogram line solver. It pops encoded line entries from the shared line FIFO and presents each one to the solver with a one-cycle valid pulse. It writes simplified lines back to the FIFO, drops lines that have collapsed to a single option, and repeats passes until the board is solved, stuck (a pass with no progress) or inconsistent.

---
 rtl/nonogram_pkg.sv | 26 ++
 rtl/sched_timeout_ctr.sv | 28 ++
 rtl/nonogram_line_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_nonogram_line_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonogram_pkg.sv
// Shared types and defaults for the nonogram line solver pipeline.
// Scheduler states and the encoding of its terminal status.
package nonogram_pkg;

    localparam int DEF_LINE_W = 1024;
    localparam int DEF_IDX_W  = 7;
    localparam int DEF_OPT_W  = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_WRBACK,
        S_CHECK,
        S_DONE
    } sched_state_t;

    typedef enum logic [1:0] {
        ST_NONE,
        ST_SOLVED,
        ST_STUCK,
        ST_ERROR
    } sched_status_t;

endpackage

// File: rtl/sched_timeout_ctr.sv
// Clearable up-counter that flags expiry after LIMIT-1 enabled cycles.
// Holds at the expiry value until cleared.
module sched_timeout_ctr #(
    parameter int LIMIT = 4096,
    parameter int W     = $clog2(LIMIT) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [W-1:0] cnt_q;

    assign expire_o = (cnt_q == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expire_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/nonogram_line_scheduler.sv
// Pass sequencer: pops lines, hands them to the solver, writes back
// unresolved lines and decides solved / stuck / error at pass ends.
module nonogram_line_scheduler
    import nonogram_pkg::*;
#(
    parameter int LINE_W     = DEF_LINE_W,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int OPT_W      = DEF_OPT_W,
    parameter int MAX_PASSES = 64,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  num_lines,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [LINE_W-1:0] fifo_dout,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [LINE_W-1:0] fifo_din,
    output logic              solver_valid,
    output logic [LINE_W-1:0] solver_line,
    input  logic              solver_done,
    input  logic [LINE_W-1:0] solver_dout,
    input  logic [OPT_W-1:0]  solver_opts,
    input  logic              solver_progress,
    output logic              busy,
    output logic              solved,
    output logic              stuck,
    output logic              error,
    output logic [IDX_W-1:0]  pass_count
);

    sched_state_t      state_q, state_d;
    sched_status_t     status_q, status_d;
    logic [IDX_W-1:0]  live_q, live_d;
    logic [IDX_W-1:0]  remain_q, remain_d;
    logic [IDX_W-1:0]  pass_q, pass_d;
    logic [IDX_W-1:0]  pass_inc;
    logic              prog_q, prog_d;
    logic              valid_q, valid_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [LINE_W-1:0] wb_q, wb_d;
    logic              tmo;

    sched_timeout_ctr #(
        .LIMIT(TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (state_q == S_LOAD),
        .en_i    (state_q == S_WAIT),
        .expire_o(tmo)
    );

    assign pass_inc     = pass_q + 1'b1;
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign solved       = (status_q == ST_SOLVED);
    assign stuck        = (status_q == ST_STUCK);
    assign error        = (status_q == ST_ERROR);
    assign pass_count   = pass_q;
    assign solver_valid = valid_q;
    assign solver_line  = line_q;
    assign fifo_din     = wb_q;

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        live_d     = live_q;
        remain_d   = remain_q;
        pass_d     = pass_q;
        prog_d     = prog_q;
        line_d     = line_q;
        wb_d       = wb_q;
        valid_d    = 1'b0;
        fifo_rd_en = 1'b0;
        fifo_wr_en = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    live_d   = num_lines;
                    remain_d = num_lines;
                    pass_d   = '0;
                    prog_d   = 1'b0;
                    status_d = ST_NONE;
                    if (num_lines == '0) begin
                        status_d = ST_SOLVED;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                line_d  = fifo_dout;
                valid_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the expiry cycle still counts as on time.
                if (solver_done) begin
                    if (solver_progress) begin
                        prog_d = 1'b1;
                    end
                    if (solver_opts == '0) begin
                        status_d = ST_ERROR;
                        state_d  = S_DONE;
                    end else if (solver_opts == OPT_W'(1)) begin
                        live_d  = live_q - 1'b1;
                        state_d = S_CHECK;
                    end else begin
                        wb_d    = solver_dout;
                        state_d = S_WRBACK;
                    end
                end else if (tmo) begin
                    status_d = ST_ERROR;
                    state_d  = S_DONE;
                end
            end
            S_WRBACK: begin
                if (!fifo_full) begin
                    fifo_wr_en = 1'b1;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                remain_d = remain_q - 1'b1;
                state_d  = S_FETCH;
                // A pass that ends without progress is not counted.
                if (remain_q == IDX_W'(1)) begin
                    if (live_q == '0) begin
                        pass_d   = pass_inc;
                        status_d = ST_SOLVED;
                        state_d  = S_DONE;
                    end else if (!prog_q) begin
                        status_d = ST_STUCK;
                        state_d  = S_DONE;
                    end else begin
                        pass_d = pass_inc;
                        if (pass_inc == IDX_W'(MAX_PASSES)) begin
                            status_d = ST_STUCK;
                            state_d  = S_DONE;
                        end else begin
                            remain_d = live_q;
                            prog_d   = 1'b0;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            status_q <= ST_NONE;
            live_q   <= '0;
            remain_q <= '0;
            pass_q   <= '0;
            prog_q   <= 1'b0;
            valid_q  <= 1'b0;
            line_q   <= '0;
            wb_q     <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            live_q   <= live_d;
            remain_q <= remain_d;
            pass_q   <= pass_d;
            prog_q   <= prog_d;
            valid_q  <= valid_d;
            line_q   <= line_d;
            wb_q     <= wb_d;
        end
    end

endmodule

// File: tb/tb_nonogram_line_scheduler.sv
// Bench for nonogram_line_scheduler: FIFO and solver models plus a
// pass-level reference model of the expected line traffic and outcome.
module tb_nonogram_line_scheduler;

    localparam int LW   = 64;
    localparam int IW   = 7;
    localparam int OW   = 7;
    localparam int MAXP = 64;
    localparam int TMO  = 16;
    localparam logic [LW-1:0] ADD = 64'h0000_0000_0001_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] num_lines = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [LW-1:0] fifo_dout = '0;
    logic          fifo_full = 1'b0;
    logic          fifo_wr_en;
    logic [LW-1:0] fifo_din;
    logic          solver_valid;
    logic [LW-1:0] solver_line;
    logic          solver_done = 1'b0;
    logic [LW-1:0] solver_dout = '0;
    logic [OW-1:0] solver_opts = '0;
    logic          solver_progress = 1'b0;
    logic          busy, solved, stuck, error;
    logic [IW-1:0] pass_count;

    nonogram_line_scheduler #(
        .LINE_W(LW), .IDX_W(IW), .OPT_W(OW),
        .MAX_PASSES(MAXP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_lines(num_lines),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .solver_valid(solver_valid), .solver_line(solver_line),
        .solver_done(solver_done), .solver_dout(solver_dout),
        .solver_opts(solver_opts), .solver_progress(solver_progress),
        .busy(busy), .solved(solved), .stuck(stuck), .error(error),
        .pass_count(pass_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [LW-1:0] fifo_q[$];
    logic [LW-1:0] exp_present[$];
    logic [LW-1:0] exp_push[$];
    int  opts_t[128];
    bit  prog_t[128];
    int  pi, wi, pops, k, lat, full_on_k;
    bit  no_done, tmo_chk;
    int  sv_cnt = 0, sv_k = 0, full_cnt = 0, cyc = 0, t_valid = 0;
    logic [LW-1:0] sv_line, dout_nx, dout_s, din_snap;
    bit  done_nx, pop_nx, snap_v, err_prev, prog_nx;
    int  opts_nx;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic chki(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    function automatic int st_of();
        return solved ? 1 : stuck ? 2 : error ? 3 : 0;
    endfunction

    task automatic set_tab(input int a, input int b, input int o, input bit p);
        for (int i = a; i <= b; i++) begin
            opts_t[i] = o;
            prog_t[i] = p;
        end
    endtask

    // Pass-level reference: status 0 none, 1 solved, 2 stuck, 3 error.
    task automatic model(input int n, input bit tmo, output int st, output int pc);
        logic [LW-1:0] q[$];
        logic [LW-1:0] ln;
        int live, cnt, kk;
        bit prog;
        exp_present.delete();
        exp_push.delete();
        q = fifo_q;
        live = n;
        kk = 0;
        pc = 0;
        st = 0;
        if (n == 0) begin
            st = 1;
            return;
        end
        forever begin
            cnt = live;
            prog = 0;
            for (int i = 0; i < cnt; i++) begin
                ln = q.pop_front();
                exp_present.push_back(ln);
                if (tmo) begin
                    st = 3;
                    return;
                end
                if (prog_t[kk]) prog = 1;
                if (opts_t[kk] == 0) begin
                    st = 3;
                    return;
                end
                if (opts_t[kk] == 1) begin
                    live--;
                end else begin
                    q.push_back(ln + ADD);
                    exp_push.push_back(ln + ADD);
                end
                kk++;
            end
            if (live == 0) begin
                pc++;
                st = 1;
                return;
            end
            if (!prog) begin
                st = 2;
                return;
            end
            pc++;
            if (pc == MAXP) begin
                st = 2;
                return;
            end
        end
    endtask

    // FIFO + solver responder and per-cycle compare; samples at negedge,
    // drives just after posedge.
    initial begin : responder
        forever begin
            @(negedge clk);
            cyc++;
            done_nx = 1'b0;
            pop_nx = 1'b0;
            if (!rst_n) begin
                sv_cnt = 0;
                full_cnt = 0;
            end else begin
                chk("rd_wr_exclusive", LW'(fifo_rd_en & fifo_wr_en), '0);
                chki("status_exclusive", ($countones({solved, stuck, error}) <= 1) ? 1 : 0, 1);
                if (solver_valid) begin
                    t_valid = cyc;
                    chki("valid_expected", (pi < exp_present.size()) ? 1 : 0, 1);
                    if (pi < exp_present.size()) chk("solver_line", solver_line, exp_present[pi]);
                    pi++;
                    if (!no_done) begin
                        sv_cnt = lat;
                        sv_line = solver_line;
                        sv_k = k;
                    end
                    k++;
                end
                if (fifo_rd_en) begin
                    pops++;
                    if (fifo_q.size() > 0) begin
                        dout_nx = fifo_q.pop_front();
                        pop_nx = 1'b1;
                    end
                end
                if (fifo_wr_en) begin
                    chki("push_expected", (wi < exp_push.size()) ? 1 : 0, 1);
                    if (wi < exp_push.size()) chk("fifo_din", fifo_din, exp_push[wi]);
                    wi++;
                    fifo_q.push_back(fifo_din);
                end
                if (fifo_full) begin
                    chk("wr_while_full", LW'(fifo_wr_en), '0);
                    if (!solver_done) begin
                        if (snap_v) chk("din_stable", fifo_din, din_snap);
                        else begin
                            din_snap = fifo_din;
                            snap_v = 1'b1;
                        end
                    end
                end
                if (full_cnt > 0) full_cnt--;
                if (sv_cnt > 0) begin
                    sv_cnt--;
                    if (sv_cnt == 0) begin
                        done_nx = 1'b1;
                        dout_s = sv_line + ADD;
                        opts_nx = opts_t[sv_k];
                        prog_nx = prog_t[sv_k];
                        if (sv_k == full_on_k) begin
                            full_cnt = 11;
                            snap_v = 1'b0;
                        end
                    end
                end
                if (tmo_chk && error && !err_prev) chki("timeout_latency", cyc - t_valid, TMO);
            end
            err_prev = error;
            @(posedge clk);
            #1;
            solver_done = done_nx;
            if (done_nx) begin
                solver_dout = dout_s;
                solver_opts = OW'(opts_nx);
                solver_progress = prog_nx;
            end
            if (pop_nx) fifo_dout = dout_nx;
            fifo_empty = (fifo_q.size() == 0);
            fifo_full = (full_cnt > 0);
        end
    end

    task automatic chk_reset(input string nm);
        chki({nm, "_busy"}, int'(busy), 0);
        chki({nm, "_status"}, int'({solved, stuck, error}), 0);
        chki({nm, "_strobes"}, int'({solver_valid, fifo_rd_en, fifo_wr_en}), 0);
        chki({nm, "_passes"}, int'(pass_count), 0);
        chk({nm, "_solver_line"}, solver_line, '0);
        chk({nm, "_fifo_din"}, fifo_din, '0);
    endtask

    task automatic run(input int tid, input int n, input int l, input bit nd, input int fk,
                       input int lit_st, input int lit_pc, input int lit_push);
        int st, pc, b;
        string p;
        p = $sformatf("t%0d", tid);
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back({8'hA0, 40'd0, 8'(tid), 8'(i)});
        lat = l;
        no_done = nd;
        full_on_k = fk;
        tmo_chk = nd;
        k = 0;
        pi = 0;
        wi = 0;
        pops = 0;
        model(n, nd, st, pc);
        chki({p, "_model_status"}, st, lit_st);
        chki({p, "_model_passes"}, pc, lit_pc);
        chki({p, "_model_pushes"}, exp_push.size(), lit_push);
        @(posedge clk);
        #1;
        num_lines = IW'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        b = 0;
        while (busy && b < 3000) begin
            start = (b == 20);
            num_lines = IW'(1);
            @(posedge clk);
            #1;
            b++;
        end
        start = 1'b0;
        chki({p, "_finish_in_time"}, (b < 3000) ? 1 : 0, 1);
        chki({p, "_status"}, st_of(), st);
        chki({p, "_pass_count"}, int'(pass_count), pc);
        chki({p, "_pushes"}, wi, exp_push.size());
        chki({p, "_presented"}, pi, exp_present.size());
        chki({p, "_pops"}, pops, exp_present.size());
    endtask

    initial begin : main
        int st, pc, b;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("reset0");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        set_tab(0, 5, 2, 1);
        set_tab(6, 11, 1, 0);
        run(1, 6, 2, 0, -1, 1, 2, 6);

        set_tab(0, 2, 3, 0);
        run(2, 3, 1, 0, -1, 2, 0, 3);

        set_tab(0, 0, 2, 1);
        set_tab(1, 3, 0, 0);
        run(3, 4, 1, 0, -1, 3, 0, 1);

        set_tab(0, 0, 2, 0);
        run(4, 1, 1, 0, 0, 2, 0, 1);

        run(5, 2, 1, 1, -1, 3, 0, 0);

        set_tab(0, 127, 2, 1);
        run(6, 1, 1, 0, -1, 2, MAXP, MAXP);

        // Abort in WAIT, then an empty board.
        fifo_q.delete();
        for (int i = 0; i < 4; i++) fifo_q.push_back({8'hB0, 48'd0, 8'(i)});
        set_tab(0, 3, 2, 1);
        lat = 50;
        no_done = 0;
        full_on_k = -1;
        tmo_chk = 0;
        k = 0;
        pi = 0;
        wi = 0;
        pops = 0;
        model(4, 0, st, pc);
        @(posedge clk);
        #1;
        num_lines = IW'(4);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        b = 0;
        while (!solver_valid && b < 50) begin
            @(posedge clk);
            #1;
            b++;
        end
        chki("t7_valid_seen", int'(solver_valid), 1);
        repeat (2) @(posedge clk);
        #1;
        chki("t7_busy_before_reset", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("t7_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fifo_q.delete();
        exp_present.delete();
        exp_push.delete();
        @(posedge clk);
        #1;
        num_lines = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chki("t7_zero_solved", int'(solved), 1);
        chki("t7_zero_idle", int'(busy), 0);
        chki("t7_zero_flags", int'({stuck, error}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
